// File: rtl/adc_channel_averager.sv
// Per-channel boxcar averager behind the MAX11643 sequencer: captures one-hot
// strobed samples, averages 2^AVG_LOG2 of them per channel, and serves results.
module adc_channel_averager #(
    parameter int AVG_LOG2 = 2,
    parameter int NUM_CH   = 9
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [7:0]        ADC_DATA,
    input  logic [NUM_CH-1:0] ADC_RDY,
    input  logic              rd,
    input  logic [3:0]        RD_CH,
    output logic [7:0]        RD_DATA,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] AVG_RDY,
    output logic              avg_upd,
    output logic [3:0]        AVG_CH,
    output logic [7:0]        AVG_DATA
);

    localparam int SW = 8 + AVG_LOG2;
    localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CW-1:0] CNT_MAX = CW'((1 << AVG_LOG2) - 1);
    localparam logic [3:0]    LAST_CH = 4'(NUM_CH - 1);

    // Stage 1: capture
    logic        s1_valid_q, s1_valid_d;
    logic [7:0]  s1_data_q, s1_data_d;
    logic [3:0]  s1_ch_q, s1_ch_d;

    always_comb begin
        s1_data_d  = ADC_DATA;
        s1_ch_d    = 4'd0;
        s1_valid_d = $onehot(ADC_RDY) && !clear;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ADC_RDY[i]) begin
                s1_ch_d = 4'(i);
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= 8'd0;
            s1_ch_q    <= 4'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_ch_q    <= s1_ch_d;
        end
    end

    // Stage 2: per-channel accumulators; done_vec flags the channel completing an average
    logic [NUM_CH-1:0]   done_vec;
    logic [NUM_CH*8-1:0] avg_vec;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [SW-1:0] acc_q, acc_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [SW-1:0] sum;
        logic          hit;
        logic          last;

        assign hit  = s1_valid_q && !clear && (s1_ch_q == 4'(gi));
        assign sum  = acc_q + SW'(s1_data_q);
        assign last = (cnt_q == CNT_MAX);

        assign done_vec[gi]         = hit && last;
        assign avg_vec[gi*8 +: 8]   = 8'(sum >> AVG_LOG2);

        always_comb begin
            acc_d = acc_q;
            cnt_d = cnt_q;
            if (clear) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (hit) begin
                if (last) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge ref_clk) begin
            if (reset) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
        end
    end

    // Result bank, flags, update pulse and read port
    logic [7:0]        bank_q [NUM_CH];
    logic [7:0]        bank_d [NUM_CH];
    logic [NUM_CH-1:0] avg_rdy_q, avg_rdy_d;
    logic              avg_upd_q, avg_upd_d;
    logic [3:0]        avg_ch_q, avg_ch_d;
    logic [7:0]        avg_data_q, avg_data_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        new_avg;
    logic              upd;
    logic              rd_in_range;

    assign upd         = |done_vec;
    assign rd_in_range = (RD_CH <= LAST_CH);

    always_comb begin
        new_avg = 8'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (done_vec[i]) begin
                new_avg = avg_vec[i*8 +: 8];
            end
        end
    end

    always_comb begin
        bank_d     = bank_q;
        avg_rdy_d  = avg_rdy_q;
        avg_upd_d  = upd;
        avg_ch_d   = avg_ch_q;
        avg_data_d = avg_data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd;

        // Read sees the pre-write bank value; a same-cycle set beats the clear.
        if (rd) begin
            if (rd_in_range) begin
                rd_data_d          = bank_q[RD_CH];
                avg_rdy_d[RD_CH]   = 1'b0;
            end else begin
                rd_data_d = 8'd0;
            end
        end

        if (upd) begin
            bank_d[s1_ch_q]    = new_avg;
            avg_rdy_d[s1_ch_q] = 1'b1;
            avg_ch_d           = s1_ch_q;
            avg_data_d         = new_avg;
        end
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            bank_q     <= '{default: '0};
            avg_rdy_q  <= '0;
            avg_upd_q  <= 1'b0;
            avg_ch_q   <= 4'd0;
            avg_data_q <= 8'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            avg_rdy_q  <= avg_rdy_d;
            avg_upd_q  <= avg_upd_d;
            avg_ch_q   <= avg_ch_d;
            avg_data_q <= avg_data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign RD_DATA  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign AVG_RDY  = avg_rdy_q;
    assign avg_upd  = avg_upd_q;
    assign AVG_CH   = avg_ch_q;
    assign AVG_DATA = avg_data_q;

endmodule

// File: doc/adc_channel_averager.md
Name: adc_channel_averager

Overview:
- Sits directly downstream of the MAX11643 sequencer.
- Consumes its 8-bit ADC_DATA and 9-bit one-hot ADC_RDY strobe.
- Averages 2^AVG_LOG2 consecutive samples per channel (channels 0..8) and holds the latest average of each channel in a register bank.
- Exposes per-channel sticky "new average" flags, a one-cycle update pulse, and a registered random-access read port for the host/register interface.

Parameters:
- AVG_LOG2, 2, log2 of samples per average; legal 0..4; 0 = pass-through (every sample is an average).
- NUM_CH, 9, channel count; fixed at 9 to match ADC_RDY width.

Ports:
- ref_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush of all accumulators/counters; bank and flags untouched.
- ADC_DATA  in  8  sample from sequencer; valid while ADC_RDY != 0.
- ADC_RDY  in  9  one-hot, one-cycle strobe; bit n = sample for channel n.
- rd  in  1  read strobe.
- RD_CH  in  4  channel to read (0..8).
- RD_DATA  out  8  registered average of RD_CH.
- rd_valid  out  1  one-cycle pulse, RD_DATA valid.
- AVG_RDY  out  9  sticky per-channel new-average flags.
- avg_upd  out  1  one-cycle pulse, a bank entry was written.
- AVG_CH  out  4  channel of the avg_upd write.
- AVG_DATA  out  8  value written, valid with avg_upd.

Behaviour:
- Reset values:
  - all outputs 0.
  - bank entries 0.
  - accumulators 0.
  - sample counters 0.
  - pipeline valid bits 0.
- Stage 1 (capture), in the cycle after ADC_RDY:
  - If ADC_RDY is exactly one-hot, register ADC_DATA, the encoded channel (0..8) and s1_valid=1.
  - ADC_RDY == 0 or multi-hot: s1_valid=0 and the sample is dropped silently.
- Stage 2 (accumulate), on s1_valid for channel c:
  - sum = ACC[c] + sample, width 8+AVG_LOG2, no overflow possible.
  - If CNT[c] == 2^AVG_LOG2-1:
    - BANK[c] <= sum >> AVG_LOG2 (truncate, no rounding).
    - ACC[c] <= 0, CNT[c] <= 0.
    - AVG_RDY[c] <= 1.
    - avg_upd=1 with AVG_CH=c, AVG_DATA=BANK value.
  - Otherwise ACC[c] <= sum, CNT[c] <= CNT[c]+1.
- Latency: ADC_RDY at cycle t → BANK/AVG_RDY/avg_upd updated at edge t+2, visible from cycle t+2.
- Back-to-back strobes on consecutive cycles, same or different channels, are accepted at full rate with no stall.
- Read port:
  - rd at cycle t → RD_DATA=BANK[RD_CH], rd_valid=1 in cycle t+1.
  - AVG_RDY[RD_CH] is cleared at the same edge.
  - RD_CH > 8: RD_DATA=0, rd_valid=1, no flag cleared.
  - RD_DATA holds its value when rd=0; rd_valid is 0 when rd=0.
- Simultaneous stage-2 write and rd to the same channel in the same cycle:
  - RD_DATA returns the old BANK value.
  - AVG_RDY[c] stays 1, because the set wins over the clear.
- clear:
  - Zeroes all ACC, CNT and s1_valid at the next edge.
  - A stage-2 update in that cycle is suppressed, and its sample is discarded.
  - BANK, AVG_RDY and the read port are unaffected.
- Reset mid-accumulation: all partial sums are lost; the first average after reset requires a full 2^AVG_LOG2 fresh samples.
- AVG_LOG2=0: every valid sample writes BANK directly, with latency unchanged (2 cycles).
- Per-channel state: 9 accumulators × (8+AVG_LOG2) bits and 9 counters × max(AVG_LOG2,1) bits.

Test Plan:
- Pass-through (AVG_LOG2=0), ADC_RDY=9'h004, ADC_DATA=8'hA5 at cycle t → avg_upd=1, AVG_CH=2, AVG_DATA=8'hA5 at t+2; AVG_RDY=9'h004; rd with RD_CH=2 → RD_DATA=8'hA5, rd_valid=1 next cycle, AVG_RDY=0 afterwards.
- Averaging (AVG_LOG2=2), channel 8 samples 10,11,12,14 → one avg_upd only, after the 4th sample, with AVG_DATA=11 (47>>2); channel 0 samples 255×4 → 255, no overflow.
- Interleaved channels 0..8, round-robin 3 times at full rate (AVG_LOG2=0) → 27 avg_upd pulses, channel order preserved, every BANK entry equals its last sample.
- Invalid strobes: ADC_RDY=9'h003 and ADC_RDY=9'h000 with data 8'hFF → no counter advance, no avg_upd, BANK unchanged.
- Collision: stage-2 write of channel 5 in the same cycle as rd of channel 5 → RD_DATA is the old value, AVG_RDY[5]=1 afterwards; RD_CH=9 → RD_DATA=0, rd_valid=1.
- clear after 2 of 4 samples on channel 1, then 4 samples of 8'h40 → a single average of 8'h40; reset asserted mid-run → all outputs 0 on the next cycle.
